// File: rtl/prog_stream_ctrl.sv
// prog_stream_ctrl: streams a program image from a byte-wide memory into a
// uart_tx, optionally preceded by a 4-byte little-endian length header.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start_i
// HDR       | load next length-header byte into tx_byte_o
// FETCH     | one-cycle image read request at addr
// WAIT_DATA | waiting (unbounded) for mem_rvalid_i
// SEND      | one-cycle tx_en_o strobe
// WAIT_DONE | waiting for tx_done_i, bounded by TIMEOUT
// GAP       | inter-byte idle time before next header/fetch or finish
module prog_stream_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int HDR_EN     = 1,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              tx_en_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic [ADDR_W-1:0] byte_cnt_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR       = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;

  logic [2:0]        state;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        hdr_idx;
  logic              hdr_act;
  logic [GW-1:0]     gap_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic [31:0]       hdr_word;

  // Header bytes beyond the length width go out as zero.
  assign hdr_word   = 32'(len);
  assign mem_req_o  = (state == S_FETCH);
  assign mem_addr_o = addr;
  assign tx_en_o    = (state == S_SEND);
  assign busy_o     = (state != S_IDLE);

  // Sequencer: abort beats timeout, timeout beats tx_done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      len        <= '0;
      addr       <= '0;
      hdr_idx    <= '0;
      hdr_act    <= 1'b0;
      gap_cnt    <= '0;
      tmo_cnt    <= '0;
      tx_byte_o  <= '0;
      byte_cnt_o <= '0;
      done_o     <= 1'b0;
      err_o      <= ERR_OK;
    end else begin
      done_o <= 1'b0;
      if (state != S_IDLE && abort_i) begin
        state   <= S_IDLE;
        err_o   <= ERR_ABORT;
        done_o  <= 1'b1;
        hdr_act <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              err_o <= ERR_OK;
              if (len_i == '0) begin
                done_o <= 1'b1;
              end else begin
                len        <= len_i;
                addr       <= '0;
                byte_cnt_o <= '0;
                hdr_idx    <= '0;
                hdr_act    <= (HDR_EN != 0);
                state      <= (HDR_EN != 0) ? S_HDR : S_FETCH;
              end
            end
          end
          S_HDR: begin
            tx_byte_o <= hdr_word[{hdr_idx, 3'b000} +: 8];
            state     <= S_SEND;
          end
          S_FETCH: begin
            // rvalid in the request cycle itself is deliberately not looked at
            state <= S_WAIT_DATA;
          end
          S_WAIT_DATA: begin
            if (mem_rvalid_i) begin
              tx_byte_o <= mem_rdata_i;
              state     <= S_SEND;
            end
          end
          S_SEND: begin
            tmo_cnt <= '0;
            state   <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (tmo_cnt == TMO_LAST) begin
              state   <= S_IDLE;
              err_o   <= ERR_TIMEOUT;
              done_o  <= 1'b1;
              hdr_act <= 1'b0;
            end else if (tx_done_i) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
              if (hdr_act) begin
                hdr_idx <= hdr_idx + 2'd1;
                if (hdr_idx == 2'd3) hdr_act <= 1'b0;
              end else begin
                byte_cnt_o <= byte_cnt_o + ADDR_W'(1);
                addr       <= addr + ADDR_W'(1);
              end
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_GAP: begin
            // a load of 0 or 1 both leave after a single GAP cycle
            if (gap_cnt > GW'(1)) begin
              gap_cnt <= gap_cnt - GW'(1);
            end else if (hdr_act) begin
              state <= S_HDR;
            end else if (addr < len) begin
              state <= S_FETCH;
            end else begin
              state  <= S_IDLE;
              err_o  <= ERR_OK;
              done_o <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_stream_ctrl.sv
// Bench for prog_stream_ctrl: unit A (no header, GAP 2, TIMEOUT 20) and
// unit B (header, GAP 0). Expected streams come from the image contents.
module tb_prog_stream_ctrl;

  typedef logic [7:0] byteq_t[$];

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // ---------------- unit A ----------------
  logic        start_a, abort_a, rvalid_a, txd_auto_a, txd_man_a;
  logic [15:0] len_a, mem_addr_a, bcnt_a;
  logic [7:0]  rdata_a, tx_byte_a;
  logic        mem_req_a, tx_en_a, busy_a, done_a;
  logic [1:0]  err_a;
  logic [7:0]  img_a [0:1023];
  int          rv_lat_a = 1, tx_lat_a = 10, rv_cd_a = 0, td_cd_a = 0, dn_a = 0, done_cyc_a = 0;
  bit          mute_a = 0;
  logic [9:0]  pa_a;
  logic [7:0]  txq_a[$];
  int          txc_a[$];
  logic [15:0] adq_a[$];
  int          rqc_a[$];

  prog_stream_ctrl #(.ADDR_W(16), .HDR_EN(0), .GAP_CYCLES(2), .TIMEOUT(20)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a), .len_i(len_a),
    .mem_req_o(mem_req_a), .mem_addr_o(mem_addr_a), .mem_rvalid_i(rvalid_a),
    .mem_rdata_i(rdata_a), .tx_en_o(tx_en_a), .tx_byte_o(tx_byte_a),
    .tx_done_i(txd_auto_a | txd_man_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a), .byte_cnt_o(bcnt_a));

  // ---------------- unit B ----------------
  logic        start_b, abort_b, rvalid_b, txd_auto_b;
  logic [15:0] len_b, mem_addr_b, bcnt_b;
  logic [7:0]  rdata_b, tx_byte_b;
  logic        mem_req_b, tx_en_b, busy_b, done_b;
  logic [1:0]  err_b;
  logic [7:0]  img_b [0:1023];
  int          rv_lat_b = 1, tx_lat_b = 2, rv_cd_b = 0, td_cd_b = 0, dn_b = 0;
  logic [9:0]  pa_b;
  logic [7:0]  txq_b[$];
  logic [15:0] adq_b[$];

  prog_stream_ctrl #(.ADDR_W(16), .HDR_EN(1), .GAP_CYCLES(0), .TIMEOUT(1000)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_b), .len_i(len_b),
    .mem_req_o(mem_req_b), .mem_addr_o(mem_addr_b), .mem_rvalid_i(rvalid_b),
    .mem_rdata_i(rdata_b), .tx_en_o(tx_en_b), .tx_byte_o(tx_byte_b),
    .tx_done_i(txd_auto_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b), .byte_cnt_o(bcnt_b));

  // Unit A memory / uart model and output monitor.
  initial begin
    rvalid_a = 0; rdata_a = 0; txd_auto_a = 0;
    forever begin
      @(negedge clk);
      if (tx_en_a) begin txq_a.push_back(tx_byte_a); txc_a.push_back(cyc); end
      if (mem_req_a) begin adq_a.push_back(mem_addr_a); rqc_a.push_back(cyc); end
      if (done_a) begin dn_a++; done_cyc_a = cyc; end
      rvalid_a = 0;
      if (rv_cd_a > 0) begin
        rv_cd_a--;
        if (rv_cd_a == 0) begin rvalid_a = 1; rdata_a = img_a[pa_a]; end
      end
      if (mem_req_a) begin rv_cd_a = rv_lat_a; pa_a = mem_addr_a[9:0]; end
      txd_auto_a = 0;
      if (td_cd_a > 0) begin
        td_cd_a--;
        if (td_cd_a == 0 && !mute_a) txd_auto_a = 1;
      end
      if (tx_en_a) td_cd_a = tx_lat_a;
    end
  end

  // Unit B memory / uart model and output monitor.
  initial begin
    rvalid_b = 0; rdata_b = 0; txd_auto_b = 0;
    forever begin
      @(negedge clk);
      if (tx_en_b) txq_b.push_back(tx_byte_b);
      if (mem_req_b) adq_b.push_back(mem_addr_b);
      if (done_b) dn_b++;
      rvalid_b = 0;
      if (rv_cd_b > 0) begin
        rv_cd_b--;
        if (rv_cd_b == 0) begin rvalid_b = 1; rdata_b = img_b[pa_b]; end
      end
      if (mem_req_b) begin rv_cd_b = rv_lat_b; pa_b = mem_addr_b[9:0]; end
      txd_auto_b = 0;
      if (td_cd_b > 0) begin
        td_cd_b--;
        if (td_cd_b == 0) txd_auto_b = 1;
      end
      if (tx_en_b) td_cd_b = tx_lat_b;
    end
  end

  // Reference: what the UART should see for a transfer of L bytes.
  function automatic byteq_t exp_stream(input bit hdr, input int L, input bit sel_b);
    byteq_t q;
    logic [31:0] w;
    w = 32'(L);
    if (hdr) for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    for (int i = 0; i < L; i++) q.push_back(sel_b ? img_b[i] : img_a[i]);
    return q;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_a(input logic [15:0] L, input int budget, output int c0, output bit ok,
                       output int tb0, output int ab0, output int db0, output logic [1:0] err_c1);
    tb0 = txq_a.size(); ab0 = adq_a.size(); db0 = dn_a;
    start_a = 1; len_a = L;
    tick(1);
    start_a = 0; c0 = cyc; err_c1 = err_a;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_a) begin ok = 1; break; end
      tick(1);
    end
    tick(3);
  endtask

  task automatic run_b(input logic [15:0] L, input int budget, output bit ok,
                       output int tb0, output int ab0, output int db0);
    tb0 = txq_b.size(); ab0 = adq_b.size(); db0 = dn_b;
    start_b = 1; len_b = L;
    tick(1);
    start_b = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_b) begin ok = 1; break; end
      tick(1);
    end
    tick(3);
  endtask

  task automatic test_reset;
    rst = 1;
    tick(2);
    total++;
    if ({busy_a, done_a, err_a, bcnt_a, tx_en_a, mem_req_a, mem_addr_a, tx_byte_a} !== '0) begin
      bad++; $display("FAIL reset_a outputs got=%0h exp=0",
        {busy_a, done_a, err_a, bcnt_a, tx_en_a, mem_req_a, mem_addr_a, tx_byte_a});
    end
    total++;
    if ({busy_b, done_b, err_b, bcnt_b, tx_en_b, mem_req_b, mem_addr_b, tx_byte_b} !== '0) begin
      bad++; $display("FAIL reset_b outputs got=%0h exp=0",
        {busy_b, done_b, err_b, bcnt_b, tx_en_b, mem_req_b, mem_addr_b, tx_byte_b});
    end
    rst = 0;
    tick(2);
    total++;
    if ({busy_a, busy_b} !== 2'b00) begin
      bad++; $display("FAIL reset_idle busy got=%b exp=00", {busy_a, busy_b});
    end
  endtask

  task automatic test_basic;
    int c0, tb0, ab0, db0, nerr;
    bit ok;
    logic [1:0] e1;
    byteq_t exp;
    rv_lat_a = 1; tx_lat_a = 10; mute_a = 0;
    img_a[0] = 8'hA5; img_a[1] = 8'h3C; img_a[2] = 8'hFF;
    run_a(16'd3, 300, c0, ok, tb0, ab0, db0, e1);
    exp = exp_stream(0, 3, 0);
    total++; if (!ok) begin bad++; $display("FAIL basic_done timeout got=0 exp=1"); end
    total++;
    if (txq_a.size() - tb0 !== 3) begin
      bad++; $display("FAIL basic_txcount got=%0d exp=3", txq_a.size() - tb0);
    end
    nerr = 0;
    for (int i = 0; i < 3; i++) begin
      if (tb0 + i >= txq_a.size()) nerr++;
      else if (txq_a[tb0+i] !== exp[i]) nerr++;
      if (ab0 + i >= adq_a.size()) nerr++;
      else if (adq_a[ab0+i] !== 16'(i)) nerr++;
    end
    total++; if (nerr != 0) begin bad++; $display("FAIL basic_bytes_addrs got=%0d errors exp=0", nerr); end
    total++; if (bcnt_a !== 16'd3) begin bad++; $display("FAIL basic_bcnt got=%0d exp=3", bcnt_a); end
    total++; if (err_a !== 2'b00) begin bad++; $display("FAIL basic_err got=%b exp=00", err_a); end
    total++; if (dn_a - db0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", dn_a - db0); end
    total++;
    if (rqc_a.size() <= ab0 || rqc_a[ab0] !== c0) begin
      bad++; $display("FAIL basic_req_latency got=%0d exp=%0d", (rqc_a.size() > ab0) ? rqc_a[ab0] - c0 + 1 : -1, 1);
    end
    total++;
    if (txc_a.size() <= tb0 || txc_a[tb0] !== c0 + 2) begin
      bad++; $display("FAIL basic_txen_latency got=%0d exp=%0d", (txc_a.size() > tb0) ? txc_a[tb0] - c0 + 1 : -1, 3);
    end
  endtask

  task automatic test_random;
    int c0, tb0, ab0, db0, nerr, L;
    bit ok;
    logic [1:0] e1;
    byteq_t exp;
    for (int it = 0; it < 4; it++) begin
      L = $urandom_range(1, 6);
      rv_lat_a = $urandom_range(1, 4);
      tx_lat_a = $urandom_range(1, 15);
      for (int i = 0; i < L; i++) img_a[i] = 8'($urandom);
      run_a(16'(L), 400, c0, ok, tb0, ab0, db0, e1);
      exp = exp_stream(0, L, 0);
      nerr = 0;
      if (txq_a.size() - tb0 != L) nerr++;
      if (adq_a.size() - ab0 != L) nerr++;
      for (int i = 0; i < L; i++) begin
        if (tb0 + i < txq_a.size() && txq_a[tb0+i] !== exp[i]) nerr++;
        if (ab0 + i < adq_a.size() && adq_a[ab0+i] !== 16'(i)) nerr++;
      end
      total++;
      if (!ok || nerr != 0) begin
        bad++; $display("FAIL random_stream it=%0d len=%0d got=%0d errors done=%0d exp=0 errors done=1", it, L, nerr, ok);
      end
      total++;
      if ({err_a, bcnt_a} !== {2'b00, 16'(L)} || dn_a - db0 != 1) begin
        bad++; $display("FAIL random_status it=%0d got err=%b bcnt=%0d dones=%0d exp err=00 bcnt=%0d dones=1",
          it, err_a, bcnt_a, dn_a - db0, L);
      end
    end
    tx_lat_a = 10; rv_lat_a = 1;
  endtask

  task automatic test_timeout;
    int c0, tb0, ab0, db0;
    bit ok;
    logic [1:0] e1;
    mute_a = 1;
    run_a(16'd2, 200, c0, ok, tb0, ab0, db0, e1);
    total++; if (!ok) begin bad++; $display("FAIL timeout_done got=0 exp=1"); end
    total++;
    if ({err_a, busy_a} !== 3'b010) begin
      bad++; $display("FAIL timeout_status got err=%b busy=%b exp err=01 busy=0", err_a, busy_a);
    end
    total++;
    if (txq_a.size() - tb0 != 1 || done_cyc_a - txc_a[txc_a.size()-1] != 21) begin
      bad++; $display("FAIL timeout_timing got tx=%0d wait=%0d exp tx=1 wait=20",
        txq_a.size() - tb0, done_cyc_a - txc_a[txc_a.size()-1] - 1);
    end
    total++; if (bcnt_a !== 16'd0) begin bad++; $display("FAIL timeout_bcnt got=%0d exp=0", bcnt_a); end
    mute_a = 0;
  endtask

  task automatic test_zero_len;
    int tb0, ab0, db0;
    bit busy_seen;
    tb0 = txq_a.size(); ab0 = adq_a.size(); db0 = dn_a;
    start_a = 1; len_a = 16'd0;
    tick(1);
    start_a = 0;
    total++;
    if ({done_a, err_a, busy_a} !== 4'b1000) begin
      bad++; $display("FAIL zero_len_pulse got done=%b err=%b busy=%b exp done=1 err=00 busy=0", done_a, err_a, busy_a);
    end
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (busy_a) busy_seen = 1; end
    total++;
    if (busy_seen || txq_a.size() != tb0 || adq_a.size() != ab0 || dn_a - db0 != 1) begin
      bad++; $display("FAIL zero_len_quiet got busy=%0d tx=%0d req=%0d dones=%0d exp 0 0 0 1",
        busy_seen, txq_a.size() - tb0, adq_a.size() - ab0, dn_a - db0);
    end
  endtask

  task automatic wait_txen_a(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (tx_en_a) begin ok = 1; break; end
    end
  endtask

  task automatic test_abort;
    int c0, tb0, ab0, db0;
    bit ok1, ok2, ok;
    logic [1:0] e1;
    mute_a = 1; rv_lat_a = 1;
    tb0 = txq_a.size();
    start_a = 1; len_a = 16'd5;
    tick(1);
    start_a = 0;
    wait_txen_a(ok1);
    tick(2); txd_man_a = 1; tick(1); txd_man_a = 0;
    wait_txen_a(ok2);
    tick(3); txd_man_a = 1; abort_a = 1;
    tick(1); txd_man_a = 0; abort_a = 0;
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL abort_setup got=%0d%0d exp=11", ok1, ok2); end
    total++;
    if ({done_a, busy_a, err_a, tx_en_a, mem_req_a} !== 6'b101000) begin
      bad++; $display("FAIL abort_status got done=%b busy=%b err=%b txen=%b req=%b exp 1 0 10 0 0",
        done_a, busy_a, err_a, tx_en_a, mem_req_a);
    end
    total++; if (bcnt_a !== 16'd1) begin bad++; $display("FAIL abort_bcnt got=%0d exp=1", bcnt_a); end
    tick(3);
    total++; if (txq_a.size() - tb0 != 2) begin bad++; $display("FAIL abort_txcount got=%0d exp=2", txq_a.size() - tb0); end
    mute_a = 0; tx_lat_a = 3;
    run_a(16'd2, 200, c0, ok, tb0, ab0, db0, e1);
    total++; if (e1 !== 2'b00) begin bad++; $display("FAIL abort_restart_err got=%b exp=00", e1); end
    total++;
    if (!ok || adq_a.size() <= ab0 || adq_a[ab0] !== 16'd0 || bcnt_a !== 16'd2) begin
      bad++; $display("FAIL abort_restart got done=%0d bcnt=%0d exp done=1 addr0=0 bcnt=2", ok, bcnt_a);
    end
    tx_lat_a = 10;
  endtask

  task automatic test_reset_mid;
    int tb0, ab0, db0;
    bit busy_seen, ok;
    rv_lat_a = 6; tx_lat_a = 10;
    start_a = 1; len_a = 16'd4;
    tick(1);
    start_a = 0;
    tick(1);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b exp=1", busy_a); end
    rst = 1;
    tick(1);
    rst = 0;
    total++;
    if ({busy_a, done_a, err_a, bcnt_a, tx_en_a, mem_req_a, mem_addr_a, tx_byte_a} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%0h exp=0",
        {busy_a, done_a, err_a, bcnt_a, tx_en_a, mem_req_a, mem_addr_a, tx_byte_a});
    end
    tb0 = txq_a.size(); busy_seen = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (busy_a) busy_seen = 1; end
    total++;
    if (busy_seen || txq_a.size() != tb0) begin
      bad++; $display("FAIL rstmid_late_rvalid got busy=%0d tx=%0d exp 0 0", busy_seen, txq_a.size() - tb0);
    end
    rv_lat_a = 1;
    tb0 = txq_a.size(); ab0 = adq_a.size(); db0 = dn_a;
    start_a = 1; len_a = 16'd2;
    tick(1);
    start_a = 0;
    tick(2);
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL busy_start_busy got=%b exp=1", busy_a); end
    start_a = 1; len_a = 16'd7;
    tick(1);
    start_a = 0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_a) begin ok = 1; break; end
      tick(1);
    end
    tick(3);
    total++;
    if (!ok || txq_a.size() - tb0 != 2 || adq_a.size() - ab0 != 2 || bcnt_a !== 16'd2 || dn_a - db0 != 1) begin
      bad++; $display("FAIL busy_start_ignored got done=%0d tx=%0d req=%0d bcnt=%0d exp 1 2 2 2",
        ok, txq_a.size() - tb0, adq_a.size() - ab0, bcnt_a);
    end
  endtask

  task automatic test_header;
    int tb0, ab0, db0, nerr;
    bit ok;
    byteq_t exp;
    rv_lat_b = 1; tx_lat_b = 2;
    for (int i = 0; i < 258; i++) img_b[i] = 8'($urandom);
    run_b(16'h0102, 5000, ok, tb0, ab0, db0);
    exp = exp_stream(1, 258, 1);
    total++; if (!ok) begin bad++; $display("FAIL hdr_done got=0 exp=1"); end
    total++;
    if (txq_b.size() - tb0 != 262) begin
      bad++; $display("FAIL hdr_txcount got=%0d exp=262", txq_b.size() - tb0);
    end
    total++;
    if (txq_b.size() < tb0 + 4 ||
        {txq_b[tb0], txq_b[tb0+1], txq_b[tb0+2], txq_b[tb0+3]} !== {exp[0], exp[1], exp[2], exp[3]}) begin
      bad++; $display("FAIL hdr_bytes got=%0h exp=%0h",
        (txq_b.size() >= tb0 + 4) ? {txq_b[tb0], txq_b[tb0+1], txq_b[tb0+2], txq_b[tb0+3]} : 32'hx,
        {exp[0], exp[1], exp[2], exp[3]});
    end
    nerr = 0;
    for (int i = 4; i < 262; i++)
      if (tb0 + i >= txq_b.size() || txq_b[tb0+i] !== exp[i]) nerr++;
    for (int i = 0; i < 258; i++)
      if (ab0 + i >= adq_b.size() || adq_b[ab0+i] !== 16'(i)) nerr++;
    total++; if (nerr != 0) begin bad++; $display("FAIL hdr_payload got=%0d errors exp=0", nerr); end
    total++;
    if ({err_b, bcnt_b} !== {2'b00, 16'h0102} || dn_b - db0 != 1) begin
      bad++; $display("FAIL hdr_status got err=%b bcnt=%0h dones=%0d exp err=00 bcnt=102 dones=1",
        err_b, bcnt_b, dn_b - db0);
    end
  endtask

  task automatic test_header_random;
    int tb0, ab0, db0, nerr, L;
    bit ok;
    byteq_t exp;
    for (int it = 0; it < 3; it++) begin
      L = $urandom_range(1, 9);
      tx_lat_b = $urandom_range(1, 8);
      rv_lat_b = $urandom_range(1, 3);
      for (int i = 0; i < L; i++) img_b[i] = 8'($urandom);
      run_b(16'(L), 600, ok, tb0, ab0, db0);
      exp = exp_stream(1, L, 1);
      nerr = 0;
      if (txq_b.size() - tb0 != exp.size()) nerr++;
      for (int i = 0; i < exp.size(); i++)
        if (tb0 + i < txq_b.size() && txq_b[tb0+i] !== exp[i]) nerr++;
      total++;
      if (!ok || nerr != 0 || bcnt_b !== 16'(L)) begin
        bad++; $display("FAIL hdr_random it=%0d len=%0d got errors=%0d done=%0d bcnt=%0d exp 0 1 %0d",
          it, L, nerr, ok, bcnt_b, L);
      end
    end
  endtask

  initial begin
    rst = 1;
    start_a = 0; abort_a = 0; len_a = '0; txd_man_a = 0;
    start_b = 0; abort_b = 0; len_b = '0;
    for (int i = 0; i < 1024; i++) begin img_a[i] = 8'($urandom); img_b[i] = 8'($urandom); end
    test_reset;
    test_basic;
    test_random;
    test_timeout;
    test_zero_len;
    test_abort;
    test_reset_mid;
    test_header;
    test_header_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_stream_ctrl.md
Name: prog_stream_ctrl

Overview:
Sequencer that streams a program image byte-by-byte from a byte-wide image memory into a uart_tx transmitter. It feeds the SoC boot programmer over UART. On start it can optionally emit a 4-byte little-endian length header, then fetches and transmits each payload byte, waiting for tx_done between bytes. It enforces a configurable inter-byte gap, a per-byte TX timeout and abort handling.

Parameters:
ADDR_W, 16, width of image address, length and byte counter
HDR_EN, 1, 1 = send 4-byte LE length header before payload; 0 = payload only
GAP_CYCLES, 2, idle cycles after each tx_done before next fetch (0 allowed)
TIMEOUT, 65535, max cycles in WAIT_DONE before timeout error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start request, sampled only in IDLE
abort_i  in  1  abort current transfer
len_i  in  ADDR_W  payload length in bytes, latched on accepted start
mem_req_o  out  1  image read request, one cycle per byte
mem_addr_o  out  ADDR_W  image byte address, valid while mem_req_o=1
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  8  read data
tx_en_o  out  1  one-cycle send strobe to uart_tx
tx_byte_o  out  8  byte to transmit
tx_done_i  in  1  uart_tx byte-complete pulse
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse on every termination
err_o  out  2  00 ok, 01 timeout, 10 aborted; held until next accepted start
byte_cnt_o  out  ADDR_W  payload bytes completed (tx_done received)

Behaviour:
- Reset (rst_i=1 at clk_i edge): state IDLE; all outputs 0; internal len, addr, header index, gap and timeout counters 0.
- States: IDLE, HDR, FETCH, WAIT_DATA, SEND, WAIT_DONE, GAP.
- IDLE with start_i=1 and len_i!=0: latch len, addr=0, byte_cnt_o=0, err_o=00. Next state is HDR (HDR_EN=1) or FETCH.
- IDLE with start_i=1 and len_i==0: done_o pulses next cycle, err_o=00, stay IDLE, no tx_en_o.
- start_i is ignored when not in IDLE.
- HDR: loads tx_byte_o=len[8k+:8] for k=0..3, then SEND. After the 4th header byte's GAP, go to FETCH. Header bytes do not count in byte_cnt_o.
- FETCH: mem_req_o=1 and mem_addr_o=addr for exactly one cycle, then WAIT_DATA.
- WAIT_DATA: wait for mem_rvalid_i with no limit. On rvalid, latch mem_rdata_i into tx_byte_o and go to SEND. An rvalid asserted during the FETCH cycle itself is ignored.
- SEND: tx_en_o=1 for exactly one cycle, then WAIT_DONE. tx_byte_o is stable from SEND until WAIT_DONE exits.
- WAIT_DONE: timeout counter starts at 0 on entry. tx_done_i=1 leads to GAP; for a payload byte, byte_cnt_o+1 and addr+1 that cycle. A tx_done_i outside WAIT_DONE is ignored.
- Timeout: if the counter reaches TIMEOUT without tx_done, go to IDLE with err_o=01 and a done_o pulse.
- GAP: wait GAP_CYCLES cycles (GAP_CYCLES=0 means leave GAP the cycle after entry). Then:
  - header bytes remaining: HDR
  - addr<len: FETCH
  - otherwise: IDLE with done_o pulse, err_o=00
- Latency (HDR_EN=0, rvalid one cycle after req): start sampled at edge 0, mem_req_o high in cycle 1, tx_en_o high in cycle 3.
- abort_i in any non-IDLE state: next cycle IDLE, err_o=10, done_o pulse, tx_en_o=0, mem_req_o=0. byte_cnt_o keeps its value. abort_i in IDLE is ignored.
- Priority in the same cycle: rst_i > abort_i > timeout > tx_done_i.
- If tx_done_i and abort_i arrive together, abort wins and byte_cnt_o does not increment.
- Counters are ADDR_W wide. len is at most 2^ADDR_W-1, so addr never wraps within a transfer.

Test Plan:
- HDR_EN=0, GAP_CYCLES=2, len_i=3, image {0xA5,0x3C,0xFF}, rvalid 1 cycle after req, tx_done 10 cycles after tx_en -> exactly 3 tx_en_o pulses carrying A5,3C,FF; mem_addr_o 0,1,2; byte_cnt_o=3; done_o one pulse; err_o=00; first tx_en_o in cycle 3.
- HDR_EN=1, len_i=0x0102 -> first 4 tx bytes 02,01,00,00, then 258 payload bytes; byte_cnt_o ends at 0x0102; exactly 262 tx_en_o pulses.
- len_i=0 with start_i -> done_o pulse next cycle, err_o=00, no mem_req_o, no tx_en_o, busy_o stays 0.
- TIMEOUT=20, tx_done_i never asserted -> done_o exactly 20 cycles after WAIT_DONE entry, err_o=01, busy_o=0.
- abort_i asserted in the same cycle as the 2nd tx_done_i of len_i=5 -> IDLE next cycle, err_o=10, byte_cnt_o=1. A later start_i restarts at mem_addr_o=0 with err_o cleared.
- rst_i mid-transfer (WAIT_DATA) -> all outputs 0 next cycle; late mem_rvalid_i ignored; start_i pulsed while busy_o=1 has no effect.
